// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 encodings, BHT counter type and reset value,
// and the legality check for conditional-branch funct3 codes.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  // Only 010 and 011 are unused encodings in the branch opcode space.
  function automatic logic is_legal_branch(input logic [2:0] funct3);
    return (funct3[2:1] != 2'b01);
  endfunction

endpackage

// File: rtl/branch_unit_bht.sv
// Branch history table: array of 2-bit saturating counters with a combinational
// prediction read and a single training write port.
module bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_taken,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  bht_ctr_t r_ctr [ENTRIES];
  bht_ctr_t w_cur;
  bht_ctr_t w_next;

  assign w_cur    = r_ctr[wr_idx];
  assign rd_taken = r_ctr[rd_idx][1];

  always_comb begin
    w_next = w_cur;
    if (wr_taken) begin
      if (w_cur != 2'b11) w_next = w_cur + 2'b01;
    end else begin
      if (w_cur != 2'b00) w_next = w_cur - 2'b01;
    end
  end

  // Counters are reset individually, so the table lives in registers rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= BHT_RESET;
    end else if (wr_en) begin
      r_ctr[wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: taken decode, mispredict check, registered redirect/flush and
// BHT training. Defining BRANCH_STATS_EN adds branch_cnt / mispred_cnt outputs.
module branch_unit
  import branch_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] pred_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [2:0]        ex_funct3,
  input  logic [DWIDTH-1:0] ex_pc,
  input  logic [DWIDTH-1:0] ex_target,
  input  logic              ex_pred_taken,
  output logic              br_un,
  input  logic              br_eq,
  input  logic              br_lt,
  output logic              redirect_valid,
  output logic [DWIDTH-1:0] redirect_pc,
`ifdef BRANCH_STATS_EN
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispred_cnt,
`endif
  output logic              flush
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic              r_redirect_valid;
  logic [DWIDTH-1:0] r_redirect_pc;
  logic              w_taken;
  logic              w_res;
  logic              w_mispred;
  logic              w_unused;

  assign br_un = ex_funct3[1];

  always_comb begin
    w_taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:           w_taken = br_eq;
      F3_BNE:           w_taken = ~br_eq;
      F3_BLT, F3_BLTU:  w_taken = br_lt;
      F3_BGE, F3_BGEU:  w_taken = ~br_lt;
      default:          w_taken = 1'b0;
    endcase
  end

  // The instruction after a mispredict is wrong-path and must neither redirect nor train.
  assign w_res     = ex_valid & ex_is_branch & is_legal_branch(ex_funct3) & ~r_redirect_valid;
  assign w_mispred = w_res & (w_taken != ex_pred_taken);

  assign w_unused = ^{pred_pc[DWIDTH-1:IW+2], pred_pc[1:0]};

  bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_pc[IW+1:2]),
    .rd_taken (pred_taken),
    .wr_en    (w_res),
    .wr_idx   (ex_pc[IW+1:2]),
    .wr_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_taken ? ex_target : ex_pc + DWIDTH'(4);
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign flush          = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_res)     r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios with literal expectations
// followed by randomized traffic, all compared against a behavioural model every cycle.
module tb_branch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        br_un;
  logic        br_eq;
  logic        br_lt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
`endif

  branch_unit #(.DWIDTH(32), .BHT_ENTRIES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .br_un          (br_un),
    .br_eq          (br_eq),
    .br_lt          (br_lt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef BRANCH_STATS_EN
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt),
`endif
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural model state: what the outputs must show after the next rising edge.
  int          m_ctr [64];
  bit          m_valid = 1'b0;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  // Hand-computed expectations for the directed part.
  bit          lit_rv_en, lit_pt_en, lit_un_en, lit_cnt_en;
  logic        lit_rv, lit_pt, lit_un;
  logic [31:0] lit_rpc, lit_bc, lit_mc;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit tk, res, mis;
    if (m_valid) begin
      chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      chk("flush", 32'(flush), 32'(m_rv));
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("pred_taken", 32'(pred_taken), 32'(m_ctr[idx(pred_pc)] >= 2));
      chk("br_un", 32'(br_un), 32'(ex_funct3 == 3'd2 || ex_funct3 == 3'd3 ||
                                   ex_funct3 == 3'd6 || ex_funct3 == 3'd7));
`ifdef BRANCH_STATS_EN
      chk("branch_cnt", branch_cnt, m_bc);
      chk("mispred_cnt", mispred_cnt, m_mc);
      if (lit_cnt_en) begin
        chk("lit_branch_cnt", branch_cnt, lit_bc);
        chk("lit_mispred_cnt", mispred_cnt, lit_mc);
      end
`endif
      if (lit_rv_en) begin
        chk("lit_redirect_valid", 32'(redirect_valid), 32'(lit_rv));
        chk("lit_redirect_pc", redirect_pc, lit_rpc);
      end
      if (lit_pt_en) chk("lit_pred_taken", 32'(pred_taken), 32'(lit_pt));
      if (lit_un_en) chk("lit_br_un", 32'(br_un), 32'(lit_un));
    end
    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_rv    = 1'b0;
      m_rpc   = 32'd0;
      m_bc    = 32'd0;
      m_mc    = 32'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      tk  = model_taken(ex_funct3, br_eq, br_lt);
      res = ex_valid && ex_is_branch && ex_funct3 != 3'd2 && ex_funct3 != 3'd3 && !m_rv;
      mis = res && (tk != ex_pred_taken);
      if (res) begin
        if (tk) m_ctr[idx(ex_pc)] = (m_ctr[idx(ex_pc)] == 3) ? 3 : m_ctr[idx(ex_pc)] + 1;
        else    m_ctr[idx(ex_pc)] = (m_ctr[idx(ex_pc)] == 0) ? 0 : m_ctr[idx(ex_pc)] - 1;
        m_bc = m_bc + 32'd1;
      end
      if (mis) begin
        m_rpc = tk ? ex_target : ex_pc + 32'd4;
        m_mc  = m_mc + 32'd1;
      end
      m_rv = mis;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    lit_rv_en    = 1'b0;
    lit_pt_en    = 1'b0;
    lit_un_en    = 1'b0;
    lit_cnt_en   = 1'b0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic eq, input logic lt, input logic pt);
    step();
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_target     = tgt;
    br_eq         = eq;
    br_lt         = lt;
    ex_pred_taken = pt;
  endtask

  task automatic expect_rv(input logic v, input logic [31:0] pc);
    lit_rv_en = 1'b1;
    lit_rv    = v;
    lit_rpc   = pc;
  endtask

  task automatic expect_pt(input logic v);
    lit_pt_en = 1'b1;
    lit_pt    = v;
  endtask

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  initial begin
    rst = 1'b1; pred_pc = 32'h80; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_funct3 = 3'd0; ex_pc = 32'd0; ex_target = 32'd0; ex_pred_taken = 1'b0;
    br_eq = 1'b0; br_lt = 1'b0;
    lit_rv_en = 1'b0; lit_pt_en = 1'b0; lit_un_en = 1'b0; lit_cnt_en = 1'b0;
    lit_rv = 1'b0; lit_pt = 1'b0; lit_un = 1'b0; lit_rpc = 32'd0; lit_bc = 32'd0; lit_mc = 32'd0;

    // Reset state
    step(); expect_rv(1'b0, 32'h0); expect_pt(1'b0);
    // BEQ taken but predicted not-taken: one-cycle redirect to target
    step(); rst = 1'b0;
    br(3'b000, 32'h200, 32'h100, 1'b1, 1'b0, 1'b0);
    step(); expect_rv(1'b1, 32'h100);
    step(); expect_rv(1'b0, 32'h100);
    // BGEU with lt=1 is not taken; predicted taken -> fall-through PC
    br(3'b111, 32'h40, 32'h999, 1'b0, 1'b1, 1'b1); lit_un_en = 1'b1; lit_un = 1'b1;
    step(); ex_funct3 = 3'b100; lit_un_en = 1'b1; lit_un = 1'b0; expect_rv(1'b1, 32'h44);
    // Train 0x80: up to strongly taken, down to strongly not-taken, saturate
    br(3'b000, 32'h80, 32'h500, 1'b1, 1'b0, 1'b1); expect_pt(1'b0);
    br(3'b000, 32'h80, 32'h500, 1'b1, 1'b0, 1'b1); expect_pt(1'b1);
    br(3'b000, 32'h80, 32'h500, 1'b1, 1'b0, 1'b1); expect_pt(1'b1);
    br(3'b000, 32'h80, 32'h500, 1'b0, 1'b0, 1'b0); expect_pt(1'b1);
    br(3'b000, 32'h80, 32'h500, 1'b0, 1'b0, 1'b0); expect_pt(1'b1);
    br(3'b000, 32'h80, 32'h500, 1'b0, 1'b0, 1'b0); expect_pt(1'b0);
    br(3'b000, 32'h80, 32'h500, 1'b0, 1'b0, 1'b0); expect_pt(1'b0);
    br(3'b000, 32'h80, 32'h500, 1'b1, 1'b0, 1'b1); expect_pt(1'b0);
    step(); expect_pt(1'b0);
    // Wrong-path resolve during redirect is ignored
    br(3'b000, 32'h80, 32'h300, 1'b1, 1'b0, 1'b0); expect_pt(1'b0);
    br(3'b000, 32'h80, 32'h700, 1'b0, 1'b0, 1'b1); expect_rv(1'b1, 32'h300); expect_pt(1'b1);
    step(); expect_rv(1'b0, 32'h300); expect_pt(1'b1);
    // Illegal funct3 is inert; PC wrap on fall-through
    br(3'b010, 32'h80, 32'h900, 1'b1, 1'b0, 1'b0); expect_pt(1'b1);
    step(); expect_rv(1'b0, 32'h300); expect_pt(1'b1);
    br(3'b000, 32'hFFFF_FFFC, 32'h123, 1'b0, 1'b0, 1'b1);
    step(); expect_rv(1'b1, 32'h0);
    // Reset beats a concurrent mispredict
    br(3'b000, 32'h200, 32'h400, 1'b1, 1'b0, 1'b0); rst = 1'b1;
    step(); rst = 1'b0; expect_rv(1'b0, 32'h0); expect_pt(1'b0);
    // Five resolved branches, two of them mispredicted
    br(3'b001, 32'h100, 32'h50, 1'b1, 1'b0, 1'b0);
    br(3'b000, 32'h100, 32'h50, 1'b1, 1'b0, 1'b0);
    step();
    br(3'b101, 32'h100, 32'h60, 1'b0, 1'b0, 1'b1);
    br(3'b110, 32'h100, 32'h60, 1'b0, 1'b0, 1'b1);
    step();
    br(3'b100, 32'h100, 32'h60, 1'b0, 1'b1, 1'b1);
    step();
`ifdef BRANCH_STATS_EN
    lit_cnt_en = 1'b1; lit_bc = 32'd5; lit_mc = 32'd2;
`endif

    // Randomized traffic with aliasing PCs and occasional resets
    for (int n = 0; n < 3000; n++) begin
      step();
      rst           = ($urandom_range(0, 199) == 0);
      ex_valid      = ($urandom_range(0, 9) != 0);
      ex_is_branch  = ($urandom_range(0, 7) != 0);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_pc         = pick_pc();
      ex_target     = $urandom;
      br_eq         = ($urandom_range(0, 3) == 0);
      br_lt         = br_eq ? 1'b0 : 1'($urandom_range(0, 1));
      ex_pred_taken = 1'($urandom_range(0, 1));
      pred_pc       = pick_pc();
    end
    step();
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
